// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter datapath and its result serializer.
// Holds the default data width, the serializer state encoding and the parity reduction helper.
package shifter_pkg;

  localparam int unsigned DataWDefault = 32;

  // Widest word the parity helper handles; narrower words are zero-extended.
  localparam int unsigned ParityMaxW = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } ser_state_e;

  function automatic logic xor_reduce(input logic [ParityMaxW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Beat counter for the serializer: synchronous clear, count enable and a terminal flag.
// Clear wins over enable so the count can return to zero on the final beat.
module ser_bit_counter #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned TERM  = 31
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/shift_result_serializer.sv
// Captures one shifter result per valid/ready handshake and streams it out one bit per beat.
// Define SER_PARITY_EN to append an even-parity beat after the data beats.
module shift_result_serializer
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDefault,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              cnt_clr, cnt_en, cnt_term;

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;
`endif

  ser_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (DATA_W - 1)
  ) u_bit_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_o (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
`ifdef SER_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          cnt_clr = 1'b1;
          state_d = StShift;
`ifdef SER_PARITY_EN
          parity_d = xor_reduce(ParityMaxW'(in_data));
`endif
        end
      end

      StShift: begin
        ser_valid = 1'b1;
        ser_out   = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
`ifdef SER_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = cnt_term;
`endif
        if (ser_ready) begin
          sreg_d = MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
          // Final beat clears instead of incrementing, so the count never reaches DATA_W.
          if (cnt_term) begin
            cnt_clr = 1'b1;
`ifdef SER_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
`endif
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

`ifdef SER_PARITY_EN
      StParity: begin
        ser_valid = 1'b1;
        ser_out   = parity_q;
        ser_last  = 1'b1;
        if (ser_ready) begin
          state_d = StIdle;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_shift_result_serializer.sv
// Directed, table-driven bench for shift_result_serializer (default DATA_W=32, MSB first).
// Build with SER_PARITY_EN defined to also check the trailing parity beat.
module tb_shift_result_serializer;

`ifdef SER_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int NumBeats = 32 + Par;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_last;
  logic        busy;

  int checks;
  int errors;
  int cnt_viol;

  shift_result_serializer #(
    .DATA_W    (32),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit counter must stay below DATA_W at all times.
  initial cnt_viol = 0;
  always @(negedge clk) begin
    if (!rst && dut.u_bit_cnt.cnt_q >= 6'd32) cnt_viol = cnt_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Handshakes one word at a negedge in IDLE, then collects beats until NumBeats are accepted.
  // mode 0: ser_ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_word(input logic [31:0] data, input int mode, input bit hold,
                          input logic [31:0] next, output logic [31:0] rx, output logic par,
                          output int beats, output int lat, output int last_bad,
                          output int hold_bad, output int busy_bad);
    int   k;
    logic prev_bit;
    bit   stalled;
    rx = '0; par = 1'b0; beats = 0; lat = 0; last_bad = 0; hold_bad = 0; busy_bad = 0;
    stalled = 1'b0; prev_bit = 1'b0;
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_data   = data;
    in_valid  = 1'b1;
    ser_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = hold;
    in_data  = hold ? next : 32'h0;
    @(negedge clk);
    k = 0;
    while (beats < NumBeats && k < 400) begin
      ser_ready = (mode == 0) || (k % 3 == 0);
      if (ser_valid) begin
        if (in_ready || !busy) busy_bad = busy_bad + 1;
        if (stalled && ser_out !== prev_bit) hold_bad = hold_bad + 1;
        if (ser_ready) begin
          if (ser_last !== (beats == NumBeats - 1)) last_bad = last_bad + 1;
          if (beats < 32) rx = {rx[30:0], ser_out};
          else par = ser_out;
          beats   = beats + 1;
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          prev_bit = ser_out;
        end
      end
      k = k + 1;
      @(negedge clk);
    end
    ser_ready = 1'b0;
    lat = in_ready ? k + 1 : -1;
  endtask

  typedef struct {
    logic [31:0] data;
    int          mode;
    bit          hold;
    logic [31:0] next;
    logic [31:0] exp_word;
    bit          exp_par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rx;
    logic        par;
    int          beats, lat, last_bad, hold_bad, busy_bad;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = 32'h0;
    in_valid  = 1'b0;
    ser_ready = 1'b0;

    vecs[0] = '{32'h8000_0001, 0, 1'b0, 32'h0,         32'h8000_0001, 1'b0};
    vecs[1] = '{32'hA5A5_A5A5, 1, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[2] = '{32'h1234_5678, 0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 0, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h0000_0000, 1, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_0007, 0, 1'b0, 32'h0,         32'h0000_0007, 1'b1};
    vecs[6] = '{32'h0000_0003, 1, 1'b0, 32'h0,         32'h0000_0003, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_ser_valid", {31'd0, ser_valid}, 32'd0);
    check("idle_ser_out", {31'd0, ser_out}, 32'd0);
    check("idle_ser_last", {31'd0, ser_last}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].data, vecs[i].mode, vecs[i].hold, vecs[i].next,
               rx, par, beats, lat, last_bad, hold_bad, busy_bad);
      check($sformatf("v%0d_word", i), rx, vecs[i].exp_word);
      check($sformatf("v%0d_beats", i), beats, NumBeats);
      check($sformatf("v%0d_last", i), last_bad, 0);
      check($sformatf("v%0d_stall_hold", i), hold_bad, 0);
      check($sformatf("v%0d_busy", i), busy_bad, 0);
      if (vecs[i].mode == 0) check($sformatf("v%0d_latency", i), lat, 33 + Par);
`ifdef SER_PARITY_EN
      check($sformatf("v%0d_parity", i), {31'd0, par}, {31'd0, vecs[i].exp_par});
`endif
    end

    // Async reset after beat 10 must kill the word between clock edges.
    in_data  = 32'hFFFF_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_valid", {31'd0, ser_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_ser_out", {31'd0, ser_out}, 32'd0);
    ser_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_word(32'h0000_0003, 0, 1'b0, 32'h0, rx, par, beats, lat, last_bad, hold_bad, busy_bad);
    check("post_rst_word", rx, 32'h0000_0003);
    check("post_rst_beats", beats, NumBeats);
    check("post_rst_last", last_bad, 0);
    check("post_rst_latency", lat, 33 + Par);

    check("cnt_bound", cnt_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
